// File: rtl/svx32_data_mem_resp.sv
// sparrowx32 data-memory responder: req/ack/valid slave over a word RAM
// with byte-lane writes, programmable wait states and external stall.
module svx32_data_mem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        pil_clk,
    input  logic        pil_rst,
    input  logic        pil_mem_req,
    input  logic        pil_mem_wen,
    input  logic [31:0] piv_mem_addr,
    input  logic [31:0] piv_mem_wdata,
    input  logic [3:0]  piv_mem_byte_sel,
    input  logic        pil_stall,
    output logic        pol_mem_ack,
    output logic        pol_mem_valid,
    output logic [31:0] pov_mem_rdata,
    output logic        pol_mem_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int SH = AW + 2;
    localparam logic [3:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          commit_wr;

    // Power-of-two depth: in range iff no offset bits above the word index.
    assign off      = piv_mem_addr - ADDR_BASE;
    assign in_range = ((off >> SH) == 32'd0);
    assign idx      = off[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (pil_mem_req) begin
                    if (WAIT_CYCLES == 0) begin
                        if (!pil_stall) begin
                            state_d = S_ACK;
                        end
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!pil_stall) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pil_clk) begin
        if (pil_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_ACK) begin
                err_q <= !in_range;
                if (!pil_mem_wen && in_range) begin
                    rdata_q <= mem[idx];
                end else begin
                    rdata_q <= 32'd0;
                end
            end
        end
    end

    // A reset on the closing edge of ACK drops the write.
    assign commit_wr = (state_q == S_ACK) && !pil_rst
                       && pil_mem_wen && in_range;

    always_ff @(posedge pil_clk) begin
        if (commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (piv_mem_byte_sel[i]) begin
                    mem[idx][8*i +: 8] <= piv_mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign pol_mem_ack   = (state_q == S_ACK);
    assign pol_mem_valid = (state_q == S_RESP);
    assign pov_mem_rdata = pol_mem_valid ? rdata_q : 32'd0;
    assign pol_mem_err   = pol_mem_valid && err_q;

endmodule

// File: tb/tb_svx32_data_mem_resp.sv
// Bench for svx32_data_mem_resp: three instances (plain, wait-state, offset base)
// checked through an expected-response queue.
module tb_svx32_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bsel;
    logic        stall;
    logic [2:0]  ack;
    logic [2:0]  valid;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    always #5 clk = ~clk;

    svx32_data_mem_resp #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_CYCLES(0)) u_a (
        .pil_clk(clk), .pil_rst(rst), .pil_mem_req(req[0]), .pil_mem_wen(wen),
        .piv_mem_addr(addr), .piv_mem_wdata(wdata), .piv_mem_byte_sel(bsel),
        .pil_stall(stall), .pol_mem_ack(ack[0]), .pol_mem_valid(valid[0]),
        .pov_mem_rdata(rdata[0]), .pol_mem_err(err[0]));

    svx32_data_mem_resp #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_CYCLES(3)) u_w (
        .pil_clk(clk), .pil_rst(rst), .pil_mem_req(req[1]), .pil_mem_wen(wen),
        .piv_mem_addr(addr), .piv_mem_wdata(wdata), .piv_mem_byte_sel(bsel),
        .pil_stall(stall), .pol_mem_ack(ack[1]), .pol_mem_valid(valid[1]),
        .pov_mem_rdata(rdata[1]), .pol_mem_err(err[1]));

    svx32_data_mem_resp #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h1000), .WAIT_CYCLES(0)) u_b (
        .pil_clk(clk), .pil_rst(rst), .pil_mem_req(req[2]), .pil_mem_wen(wen),
        .piv_mem_addr(addr), .piv_mem_wdata(wdata), .piv_mem_byte_sel(bsel),
        .pil_stall(stall), .pol_mem_ack(ack[2]), .pol_mem_valid(valid[2]),
        .pov_mem_rdata(rdata[2]), .pol_mem_err(err[2]));

    typedef struct {
        int          inst;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [2:0] ack_q = 3'b000;
    int   ack_cnt [3] = '{0, 0, 0};
    int   val_cnt [3] = '{0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (ack_q[i]) check("valid_after_ack", 32'(valid[i]), 32'd1);
            if (ack[i] === 1'b1) begin
                check("ack_single_cycle", 32'(ack_q[i]), 32'd0);
                if (!rst) ack_cnt[i]++;
            end
            if (valid[i] === 1'b1) begin
                val_cnt[i]++;
                check("valid_follows_ack", 32'(ack_q[i]), 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("resp_inst", 32'(i), 32'(e.inst));
                    check("resp_rdata", rdata[i], e.rd);
                    check("resp_err", 32'(err[i]), 32'(e.er));
                end
            end
        end
        ack_q = ack & {3{!rst}};
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in the RESP cycle, so a following call issues back-to-back.
    task automatic do_access(input int inst, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             input logic [31:0] exp_rd, input logic exp_er,
                             input int exp_lat, input int st_from, input int st_len);
        exp_t e;
        int   lat;
        bit   got;
        lat = 0;
        got = 0;
        e.inst = inst;
        e.rd = exp_rd;
        e.er = exp_er;
        sb.push_back(e);
        wen = w;
        addr = a;
        wdata = d;
        bsel = be;
        req[inst] = 1'b1;
        while (!got && lat < 40) begin
            stall = (lat >= st_from) && (lat < st_from + st_len);
            @(posedge clk);
            #1;
            lat++;
            if (ack[inst]) got = 1;
        end
        stall = 1'b0;
        if (!got) begin
            check("ack_timeout", 32'(lat), 32'(exp_lat));
            req[inst] = 1'b0;
            void'(sb.pop_back());
        end else begin
            check("ack_latency", 32'(lat), 32'(exp_lat));
            @(posedge clk);
            #1;
            req[inst] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        tbl[0]  = '{1'b1, 32'h10,   32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,         4'b1111, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h20,   32'h1122_3344, 4'b1111, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 32'h20,   32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 32'h20,   32'h0,         4'b0001, 32'h11BB_33DD, 1'b0};
        tbl[5]  = '{1'b1, 32'h24,   32'h5566_7788, 4'b1111, 32'h0,         1'b0};
        tbl[6]  = '{1'b1, 32'h24,   32'hFFFF_FFFF, 4'b0000, 32'h0,         1'b0};
        tbl[7]  = '{1'b0, 32'h24,   32'h0,         4'b0000, 32'h5566_7788, 1'b0};
        tbl[8]  = '{1'b0, 32'h13,   32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
        tbl[9]  = '{1'b1, 32'h30,   32'h0,         4'b1111, 32'h0,         1'b0};
        tbl[10] = '{1'b1, 32'hFFC,  32'h0BAD_F00D, 4'b1111, 32'h0,         1'b0};
        tbl[11] = '{1'b1, 32'h4,    32'h0,         4'b1111, 32'h0,         1'b0};
        tbl[12] = '{1'b0, 32'h1000, 32'h0,         4'b1111, 32'h0,         1'b1};
        tbl[13] = '{1'b1, 32'h1004, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1};
        tbl[14] = '{1'b0, 32'h4,    32'h0,         4'b0000, 32'h0,         1'b0};
        tbl[15] = '{1'b0, 32'hFFC,  32'h0,         4'b0000, 32'h0BAD_F00D, 1'b0};

        rst = 1'b1;
        req = 3'b000;
        wen = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        bsel = 4'h0;
        stall = 1'b0;
        cycles(3);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("reset_ack", 32'(ack[i]), 32'd0);
            check("reset_valid", 32'(valid[i]), 32'd0);
            check("reset_err", 32'(err[i]), 32'd0);
            check("reset_rdata", rdata[i], 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            do_access(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be,
                      tbl[i].rd, tbl[i].er, 1, 0, 0);
            cycles(2);
        end

        // Wait states: stall at cnt==0 for 2 cycles, then stall during IDLE.
        do_access(1, 1'b1, 32'h40, 32'hCAFE_BABE, 4'b1111, 32'h0, 1'b0, 6, 3, 2);
        cycles(2);
        do_access(1, 1'b0, 32'h40, 32'h0, 4'b1111, 32'hCAFE_BABE, 1'b0, 4, 0, 1);
        cycles(2);

        // Offset base with out-of-range accesses on either side.
        do_access(2, 1'b1, 32'h1000, 32'h0101_0101, 4'b1111, 32'h0, 1'b0, 1, 0, 0);
        do_access(2, 1'b1, 32'h1FFC, 32'h0202_0202, 4'b1111, 32'h0, 1'b0, 1, 0, 0);
        do_access(2, 1'b0, 32'h2000, 32'h0, 4'b1111, 32'h0, 1'b1, 1, 0, 0);
        do_access(2, 1'b1, 32'h0FFC, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1, 1, 0, 0);
        do_access(2, 1'b0, 32'h1000, 32'h0, 4'b0000, 32'h0101_0101, 1'b0, 1, 0, 0);
        do_access(2, 1'b0, 32'h1FFC, 32'h0, 4'b0000, 32'h0202_0202, 1'b0, 1, 0, 0);
        cycles(2);

        // Eight accesses reissued in each RESP cycle.
        for (int i = 0; i < 4; i++) begin
            do_access(0, 1'b1, 32'h100 + 32'(4*i), 32'hA5A5_0000 + 32'(i),
                      4'b1111, 32'h0, 1'b0, 1, 0, 0);
            do_access(0, 1'b0, 32'h100 + 32'(4*i), 32'h0, 4'b1111,
                      32'hA5A5_0000 + 32'(i), 1'b0, 1, 0, 0);
        end
        cycles(2);

        // Reset during the ACK cycle of a write to 0x30.
        wen = 1'b1;
        addr = 32'h30;
        wdata = 32'hCAFE_F00D;
        bsel = 4'b1111;
        req[0] = 1'b1;
        cycles(1);
        check("abort_ack_seen", 32'(ack[0]), 32'd1);
        rst = 1'b1;
        req[0] = 1'b0;
        cycles(1);
        rst = 1'b0;
        check("abort_ack", 32'(ack[0]), 32'd0);
        check("abort_valid", 32'(valid[0]), 32'd0);
        check("abort_rdata", rdata[0], 32'd0);
        check("abort_err", 32'(err[0]), 32'd0);
        cycles(3);
        do_access(0, 1'b0, 32'h30, 32'h0, 4'b1111, 32'h0, 1'b0, 1, 0, 0);
        cycles(3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("ack_valid_count", 32'(val_cnt[i]), 32'(ack_cnt[i]));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
